// File: rtl/muldiv_hilo_ctrl_pkg.sv
// muldiv_pkg: op encodings, controller states and cycle constants for the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int WIDTH_DEF = 32;
  localparam int DIV_CYCLES = WIDTH_DEF + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if: EX-stage request/response bundle for the multiply/divide unit.
interface muldiv_hilo_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_req;
  logic             flush;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, src_a, src_b, rd_req, flush, input busy, stall, hi, lo);
  modport slave(input start, op, src_a, src_b, rd_req, flush, output busy, stall, hi, lo);
endinterface

// File: rtl/muldiv_hilo_ctrl_div_iter.sv
// div_iter: unsigned restoring divider producing one quotient bit per step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  // remainder < divisor always holds, so a negative trial shows up in the top bit
  assign t = {remainder, quotient[WIDTH-1]};
  assign diff = t - {1'b0, d};
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient <= '0;
      remainder <= '0;
      d <= '0;
    end else if (load) begin
      quotient <= dividend;
      remainder <= '0;
      d <= divisor;
    end else if (step) begin
      remainder <= diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
      quotient <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
    end
  end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: sequences multi-cycle multiply/divide and owns the HI/LO registers.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  muldiv_hilo_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t             state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] pend;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   aux;
  logic               busy;
  logic               q_neg;
  logic               r_neg;
  logic               dz;
  logic               ovf;
  logic               accept;
  logic               sgn;
  logic               is_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  assign a = bus.src_a;
  assign b = bus.src_b;
  assign accept = state == IDLE && bus.start && !bus.flush;
  assign sgn = ~bus.op[0];
  assign is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
  assign ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign mag_a = (sgn & a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn & b[WIDTH-1]) ? -b : b;
  assign bus.busy = busy;
  assign bus.stall = busy & (bus.start | bus.rd_req);
  assign bus.hi = hi;
  assign bus.lo = lo;
  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .reset(reset),
    .load(accept && is_div),
    .step(state == DIV),
    .dividend(mag_a),
    .divisor(mag_b),
    .quotient(quo),
    .remainder(rem)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      pend <= '0;
      aux <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
    end else if (state != IDLE && bus.flush) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend <= ext_a * ext_b;
              cnt <= 6'(MUL_CYCLES - 1);
              state <= MUL;
              busy <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              q_neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg <= sgn & a[WIDTH-1];
              dz <= b == '0;
              ovf <= sgn && a == MIN && b == '1;
              aux <= a;
              cnt <= 6'(WIDTH - 1);
              state <= DIV;
              busy <= 1'b1;
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
          endcase
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= pend;
            state <= IDLE;
            busy <= 1'b0;
          end else cnt <= cnt - 6'd1;
        end
        DIV: begin
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 6'd1;
        end
        FIX: begin
          lo <= dz ? '1 : ovf ? MIN : q_neg ? -quo : quo;
          hi <= dz ? aux : ovf ? '0 : r_neg ? -rem : rem;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
